// File: rtl/uart_row_loader.sv
// ============================================================================
// Module   : uart_row_loader
// Purpose  : UART frame parser that commits one verified display row into a
//            double-buffered row register and answers with response codes.
// Revision : 1.0
// ============================================================================
`default_nettype none

module uart_row_loader #(
    parameter int         ROW_BYTES  = 240,
    parameter int         ROWS       = 480,
    parameter int         ROW_W      = 9,
    parameter int         ACK_EVERY  = 16,
    parameter int         ACK_GAP    = 16,
    parameter int         TIMEOUT    = 2_000_000,
    parameter logic [7:0] START_CODE = 8'hA5,
    parameter logic [7:0] END_CODE   = 8'hDD,
    parameter logic [7:0] ROW_ACK    = 8'hCC,
    parameter logic [7:0] ACK_CODE   = 8'hAA,
    parameter logic [7:0] OK_CODE    = 8'hBC,
    parameter logic [7:0] NACK_CODE  = 8'h11
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [7:0]             rx_data,
    input  logic                   rx_valid,
    input  logic                   tx_busy,
    output logic [7:0]             tx_data,
    output logic                   tx_start,
    output logic [ROW_W-1:0]       row_addr,
    output logic [8*ROW_BYTES-1:0] row_data,
    output logic                   done,
    output logic                   err,
    output logic                   frame_active
);

    localparam int CNT_W   = $clog2(ROW_BYTES + 1);
    localparam int BLK_DIV = (ACK_EVERY == 0) ? 1 : ACK_EVERY;
    localparam int BLK_W   = $clog2(BLK_DIV + 1);
    localparam int GAP_W   = $clog2(ACK_GAP + 2);
    localparam int TO_W    = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ADDR_HI = 3'd1,
        S_ADDR_LO = 3'd2,
        S_PAYLOAD = 3'd3,
        S_CSUM    = 3'd4,
        S_END     = 3'd5,
        S_RESP    = 3'd6
    } state_t;

    state_t                   r_state;
    state_t                   r_ret;
    logic [CNT_W-1:0]         r_cnt;
    logic [BLK_W-1:0]         r_blk;
    logic [7:0]               r_csum;
    logic [7:0]               r_addr_hi;
    logic [7:0]               r_resp;
    logic [8*ROW_BYTES-1:0]   r_shadow;
    logic [ROW_W-1:0]         r_shadow_addr;
    logic                     r_match;
    logic                     r_sent;
    logic [GAP_W-1:0]         r_gap;
    logic [TO_W-1:0]          r_tout;

    logic [15:0]              w_addr16;
    logic                     w_addr_ok;
    logic [CNT_W-1:0]         w_cnt_nxt;
    logic                     w_last;
    logic [BLK_W-1:0]         w_blk_nxt;
    logic                     w_blk_hit;
    logic                     w_gap_done;
    logic                     w_timeout;

    assign w_addr16   = {r_addr_hi, rx_data};
    assign w_addr_ok  = (int'({16'd0, w_addr16}) < ROWS) &&
                        ((32'({16'd0, w_addr16}) >> ROW_W) == 32'd0);
    assign w_cnt_nxt  = r_cnt + CNT_W'(1);
    assign w_last     = (w_cnt_nxt == CNT_W'(ROW_BYTES));
    assign w_blk_nxt  = r_blk + BLK_W'(1);
    assign w_blk_hit  = (ACK_EVERY != 0) && (w_blk_nxt == BLK_W'(BLK_DIV));
    assign w_gap_done = (int'({1'b0, r_gap}) + 1 >= ACK_GAP);
    assign w_timeout  = (int'({1'b0, r_tout}) == TIMEOUT - 1);

    assign frame_active = (r_state != S_IDLE);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state       <= S_IDLE;
            r_ret         <= S_IDLE;
            r_cnt         <= '0;
            r_blk         <= '0;
            r_csum        <= '0;
            r_addr_hi     <= '0;
            r_resp        <= '0;
            r_shadow      <= '0;
            r_shadow_addr <= '0;
            r_match       <= 1'b0;
            r_sent        <= 1'b0;
            r_gap         <= '0;
            r_tout        <= '0;
            tx_data       <= '0;
            tx_start      <= 1'b0;
            row_addr      <= '0;
            row_data      <= '0;
            done          <= 1'b0;
            err           <= 1'b0;
        end else begin
            tx_start <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_tout <= '0;
                    if (rx_valid && rx_data == START_CODE) begin
                        r_state <= S_ADDR_HI;
                        r_cnt   <= '0;
                        r_blk   <= '0;
                        r_csum  <= '0;
                    end
                end
                S_RESP: begin
                    r_tout <= '0;
                    if (r_sent) begin
                        r_sent  <= 1'b0;
                        r_state <= rx_valid ? S_IDLE : r_ret;
                        err     <= rx_valid;
                    end else if (rx_valid) begin
                        // Byte arrived while a response is pending: drop it and abort.
                        r_resp <= NACK_CODE;
                        r_ret  <= S_IDLE;
                        err    <= 1'b1;
                    end else if (w_gap_done && !tx_busy) begin
                        tx_start <= 1'b1;
                        tx_data  <= r_resp;
                        r_sent   <= 1'b1;
                    end else if (!w_gap_done) begin
                        r_gap <= r_gap + GAP_W'(1);
                    end
                end
                default: begin
                    if (rx_valid) begin
                        r_tout <= '0;
                        case (r_state)
                            S_ADDR_HI: begin
                                r_addr_hi <= rx_data;
                                r_state   <= S_ADDR_LO;
                            end
                            S_ADDR_LO: begin
                                r_state <= S_RESP;
                                r_gap   <= '0;
                                r_sent  <= 1'b0;
                                if (w_addr_ok) begin
                                    r_shadow_addr <= w_addr16[ROW_W-1:0];
                                    r_resp        <= ROW_ACK;
                                    r_ret         <= S_PAYLOAD;
                                end else begin
                                    r_resp <= NACK_CODE;
                                    r_ret  <= S_IDLE;
                                    err    <= 1'b1;
                                end
                            end
                            S_PAYLOAD: begin
                                for (int k = 0; k < ROW_BYTES; k++) begin
                                    if (r_cnt == CNT_W'(k)) begin
                                        r_shadow[8*k +: 8] <= rx_data;
                                    end
                                end
                                r_csum <= r_csum ^ rx_data;
                                r_cnt  <= w_cnt_nxt;
                                if (w_last) begin
                                    r_state <= S_CSUM;
                                end else if (w_blk_hit) begin
                                    r_blk   <= '0;
                                    r_resp  <= ACK_CODE;
                                    r_ret   <= S_PAYLOAD;
                                    r_state <= S_RESP;
                                    r_gap   <= '0;
                                    r_sent  <= 1'b0;
                                end else begin
                                    r_blk <= w_blk_nxt;
                                end
                            end
                            S_CSUM: begin
                                r_match <= (rx_data == r_csum);
                                r_state <= S_END;
                            end
                            default: begin
                                r_state <= S_RESP;
                                r_ret   <= S_IDLE;
                                r_gap   <= '0;
                                r_sent  <= 1'b0;
                                if (rx_data == END_CODE && r_match) begin
                                    row_data <= r_shadow;
                                    row_addr <= r_shadow_addr;
                                    done     <= 1'b1;
                                    r_resp   <= OK_CODE;
                                end else begin
                                    r_resp <= NACK_CODE;
                                    err    <= 1'b1;
                                end
                            end
                        endcase
                    end else if (w_timeout) begin
                        r_tout  <= '0;
                        r_resp  <= NACK_CODE;
                        r_ret   <= S_IDLE;
                        r_state <= S_RESP;
                        r_gap   <= '0;
                        r_sent  <= 1'b0;
                        err     <= 1'b1;
                    end else begin
                        r_tout <= r_tout + TO_W'(1);
                    end
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_uart_row_loader.sv
// ============================================================================
// Module   : tb_uart_row_loader
// Purpose  : Self-checking bench for uart_row_loader (4-byte rows, ack every 2).
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_uart_row_loader;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_valid = 1'b0;
    logic        tx_busy = 1'b0;
    logic [7:0]  tx_data;
    logic        tx_start;
    logic [8:0]  row_addr;
    logic [31:0] row_data;
    logic        done;
    logic        err;
    logic        frame_active;

    uart_row_loader #(
        .ROW_BYTES (4),
        .ROWS      (480),
        .ROW_W     (9),
        .ACK_EVERY (2),
        .ACK_GAP   (4),
        .TIMEOUT   (100)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .tx_busy      (tx_busy),
        .tx_data      (tx_data),
        .tx_start     (tx_start),
        .row_addr     (row_addr),
        .row_data     (row_data),
        .done         (done),
        .err          (err),
        .frame_active (frame_active)
    );

    always #5 clk = ~clk;

    // Response byte k of a frame lives in txs[8k+7:8k].
    typedef struct {
        logic [7:0]  hi;
        logic [7:0]  lo;
        logic [31:0] payload;
        logic [7:0]  csum;
        logic [7:0]  endb;
        int          ntx;
        logic [23:0] txs;
        int          dn;
        int          er;
        logic [8:0]  raddr;
        logic [31:0] rdata;
    } vec_t;

    int         checks = 0;
    int         errors = 0;
    logic [7:0] txq[$];
    int         done_cnt = 0;
    int         err_cnt = 0;
    int         busy_viol = 0;
    logic       busy_q = 1'b0;

    always @(posedge clk) busy_q <= tx_busy;

    always @(negedge clk) begin
        if (tx_start) begin
            txq.push_back(tx_data);
            if (busy_q) busy_viol++;
        end
        if (done) done_cnt++;
        if (err) err_cnt++;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        tick();
        rx_valid = 1'b0;
    endtask

    task automatic wait_tx(input int n, input string name);
        for (int i = 0; i < 400 && txq.size() < n; i++) tick();
        check({name, "_arrived"}, 64'(txq.size() >= n), 64'd1);
    endtask

    task automatic run_frame(input vec_t v, input int idx);
        int         d0;
        int         e0;
        logic [7:0] got;
        txq.delete();
        d0 = done_cnt;
        e0 = err_cnt;
        send_byte(8'hA5);
        send_byte(v.hi);
        send_byte(v.lo);
        wait_tx(1, $sformatf("v%0d_r1", idx));
        if (v.ntx == 3) begin
            send_byte(v.payload[7:0]);
            send_byte(v.payload[15:8]);
            wait_tx(2, $sformatf("v%0d_r2", idx));
            send_byte(v.payload[23:16]);
            send_byte(v.payload[31:24]);
            send_byte(v.csum);
            send_byte(v.endb);
            wait_tx(3, $sformatf("v%0d_r3", idx));
        end
        tick();
        tick();
        for (int i = 0; i < v.ntx; i++) begin
            got = (i < txq.size()) ? txq[i] : 8'h00;
            check($sformatf("v%0d_tx%0d", idx, i), 64'(got), 64'(v.txs[8*i +: 8]));
        end
        check($sformatf("v%0d_ntx", idx), 64'(txq.size()), 64'(v.ntx));
        check($sformatf("v%0d_done", idx), 64'(done_cnt - d0), 64'(v.dn));
        check($sformatf("v%0d_err", idx), 64'(err_cnt - e0), 64'(v.er));
        check($sformatf("v%0d_row_addr", idx), 64'(row_addr), 64'(v.raddr));
        check($sformatf("v%0d_row_data", idx), 64'(row_data), 64'(v.rdata));
        check($sformatf("v%0d_idle", idx), 64'(frame_active), 64'd0);
    endtask

    initial begin
        vec_t vecs[7];
        vec_t v;
        int   e0;

        vecs[0] = '{8'h00, 8'h07, 32'h44332211, 8'h44, 8'hDD, 3, 24'hBCAACC, 1, 0, 9'd7,   32'h44332211};
        vecs[1] = '{8'h00, 8'h08, 32'h55667788, 8'hCD, 8'hDD, 3, 24'h11AACC, 0, 1, 9'd7,   32'h44332211};
        vecs[2] = '{8'h00, 8'h09, 32'h0D0C0B0A, 8'h00, 8'hDC, 3, 24'h11AACC, 0, 1, 9'd7,   32'h44332211};
        vecs[3] = '{8'h01, 8'hE0, 32'h00000000, 8'h00, 8'h00, 1, 24'h000011, 0, 1, 9'd7,   32'h44332211};
        vecs[4] = '{8'h01, 8'hDF, 32'hDDCCBBAA, 8'h00, 8'hDD, 3, 24'hBCAACC, 1, 0, 9'h1DF, 32'hDDCCBBAA};
        vecs[5] = '{8'h02, 8'h00, 32'h00000000, 8'h00, 8'h00, 1, 24'h000011, 0, 1, 9'h1DF, 32'hDDCCBBAA};
        vecs[6] = '{8'h00, 8'h00, 32'h08040201, 8'h0F, 8'hDD, 3, 24'hBCAACC, 1, 0, 9'd0,   32'h08040201};

        rst_n = 1'b0;
        repeat (3) tick();
        check("rst_tx_data", 64'(tx_data), 64'd0);
        check("rst_tx_start", 64'(tx_start), 64'd0);
        check("rst_row_addr", 64'(row_addr), 64'd0);
        check("rst_row_data", 64'(row_data), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_err", 64'(err), 64'd0);
        check("rst_frame_active", 64'(frame_active), 64'd0);
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < 7; i++) run_frame(vecs[i], i);

        // Stall after two payload bytes; the abort lands on the 100th idle edge.
        txq.delete();
        e0 = err_cnt;
        send_byte(8'hA5);
        send_byte(8'h00);
        send_byte(8'h03);
        wait_tx(1, "to_r1");
        send_byte(8'h11);
        send_byte(8'h22);
        wait_tx(2, "to_r2");
        repeat (99) tick();
        check("to_no_early_err", 64'(err_cnt - e0), 64'd0);
        check("to_still_active", 64'(frame_active), 64'd1);
        tick();
        check("to_err_pulse", 64'(err), 64'd1);
        wait_tx(3, "to_r3");
        check("to_nack", 64'(txq[2]), 64'h11);
        tick();
        check("to_idle", 64'(frame_active), 64'd0);
        check("to_row_addr_kept", 64'(row_addr), 64'd0);
        v = '{8'h00, 8'h0A, 32'h44332211, 8'h44, 8'hDD, 3, 24'hBCAACC, 1, 0, 9'd10, 32'h44332211};
        run_frame(v, 7);

        // Transmitter busy for 50 cycles after RESP entry, then a byte injected during RESP.
        txq.delete();
        e0 = err_cnt;
        tx_busy = 1'b1;
        send_byte(8'hA5);
        send_byte(8'h00);
        send_byte(8'h05);
        repeat (49) tick();
        check("bp_no_early_tx", 64'(txq.size()), 64'd0);
        check("bp_no_early_start", 64'(tx_start), 64'd0);
        tx_busy = 1'b0;
        tick();
        check("bp_start_first_free", 64'(tx_start), 64'd1);
        check("bp_tx_data", 64'(tx_data), 64'hCC);
        tick();
        send_byte(8'h11);
        send_byte(8'h22);
        send_byte(8'h33);
        wait_tx(2, "viol_r2");
        check("viol_nack", 64'(txq[1]), 64'h11);
        tick();
        check("viol_idle", 64'(frame_active), 64'd0);
        check("viol_err", 64'(err_cnt - e0), 64'd1);
        check("viol_row_addr_kept", 64'(row_addr), 64'd10);

        // Reset mid-payload clears committed outputs and cancels the frame.
        txq.delete();
        send_byte(8'hA5);
        send_byte(8'h00);
        send_byte(8'h09);
        wait_tx(1, "rp_r1");
        send_byte(8'h11);
        rst_n = 1'b0;
        tick();
        check("rp_row_data", 64'(row_data), 64'd0);
        check("rp_row_addr", 64'(row_addr), 64'd0);
        check("rp_tx_data", 64'(tx_data), 64'd0);
        check("rp_tx_start", 64'(tx_start), 64'd0);
        check("rp_done_err", 64'({done, err}), 64'd0);
        check("rp_frame_active", 64'(frame_active), 64'd0);
        tick();
        rst_n = 1'b1;
        repeat (20) tick();
        check("rp_no_response", 64'(txq.size()), 64'd1);
        send_byte(8'h00);
        send_byte(8'hDD);
        repeat (10) tick();
        check("junk_idle", 64'(frame_active), 64'd0);
        check("junk_no_tx", 64'(txq.size()), 64'd1);
        run_frame(vecs[0], 8);

        check("tx_start_while_busy", 64'(busy_viol), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/uart_row_loader.md
# uart_row_loader

Parametrised UART framing controller that loads one display row per frame into a double-buffered row register for the VGA path. It sits between `uart_receiver` (byte strobes in) and `uart_transmiter` (response bytes out). Compared with the previous row loader it adds:
- a generic row size and row-address width;
- a two-byte row address with range check;
- an XOR checksum;
- block-wise acknowledges;
- an inter-byte timeout;
- atomic commit of the row only on a fully verified frame.

## Interface
Parameters:
- ROW_BYTES, 240: payload bytes per row; row_data width is 8*ROW_BYTES.
- ROWS, 480: valid row addresses are 0..ROWS-1.
- ROW_W, 9: row_addr width, 1..16.
- ACK_EVERY, 16: send ACK_CODE after every ACK_EVERY payload bytes (never after the last byte); 0 disables block acks.
- ACK_GAP, 16: cycles between entering RESP and the earliest tx_start.
- TIMEOUT, 2_000_000: maximum idle cycles between bytes inside a frame.
- START_CODE 8'hA5, END_CODE 8'hDD, ROW_ACK 8'hCC, ACK_CODE 8'hAA, OK_CODE 8'hBC, NACK_CODE 8'h11.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, synchronous, active-low.
- rx_data  in  8  received byte, valid with rx_valid.
- rx_valid  in  1  one-cycle strobe per received byte.
- tx_busy  in  1  transmitter busy.
- tx_data  out  8  response byte, held stable from tx_start until the next response.
- tx_start  out  1  one-cycle transmit request.
- row_addr  out  ROW_W  address of the last committed row.
- row_data  out  8*ROW_BYTES  committed row; byte k occupies bits [8k+7:8k].
- done  out  1  one-cycle pulse on commit.
- err  out  1  one-cycle pulse on any frame abort.
- frame_active  out  1  high in every state except IDLE.

## Operation
- Frame format: START_CODE, addr_hi, addr_lo, ROW_BYTES payload bytes, checksum, END_CODE.
- States:
  - IDLE: rx START_CODE -> ADDR_HI; any other byte is ignored.
  - ADDR_HI: rx -> ADDR_LO.
  - ADDR_LO: rx -> form the 16-bit address {hi,lo}. If it is >= ROWS or exceeds ROW_W bits, queue NACK_CODE and abort. Otherwise latch it to the shadow address and queue ROW_ACK -> RESP, then return to PAYLOAD.
  - PAYLOAD: each rx writes byte cnt of the shadow buffer, XORs it into csum, and increments cnt.
    - cnt reaching ROW_BYTES -> CSUM.
    - Otherwise, if ACK_EVERY != 0 and cnt % ACK_EVERY == 0, queue ACK_CODE -> RESP.
  - CSUM: rx -> store the match flag (rx_data == csum) -> END.
  - END: rx == END_CODE and match -> commit (row_data <= shadow, row_addr <= shadow address, done pulse) and queue OK_CODE. Otherwise queue NACK_CODE and pulse err. Then RESP -> IDLE.
  - RESP: wait ACK_GAP cycles, then wait for tx_busy low. Issue tx_start with the queued byte, then go to the stored return state.
- Abort (address out of range, timeout, rx during RESP, bad end/checksum):
  - err pulses.
  - The NACK_CODE response is sent via RESP, then the FSM returns to IDLE.
  - The shadow buffer is discarded; row_data and row_addr are unchanged.
- rx_valid during RESP is a protocol violation. The byte is dropped, the queued byte is overwritten with NACK_CODE (unless tx_start has already been issued), and the return state becomes IDLE.
- Timeout counter:
  - Runs in ADDR_HI..END, clears on each rx_valid, and clears on entry to those states.
  - Reaching TIMEOUT aborts the frame.
  - It does not run in IDLE or RESP.
- cnt width is $clog2(ROW_BYTES+1). csum is 8 bits and is cleared on START_CODE. The shadow buffer is not cleared; unwritten bytes cannot commit.

## Timing
- Reset values: tx_data 0, tx_start 0, row_addr 0, row_data 0, done 0, err 0, frame_active 0; FSM in IDLE, cnt 0, csum 0.
- rst_n low mid-frame: IDLE on the next edge, no response is sent, and committed outputs return to 0.
- All rx handling is registered, so state and storage update on the edge where rx_valid is sampled high.
- done, row_data and row_addr change on the same edge, one cycle after the END_CODE strobe. Entry into RESP happens on that same edge.
- err pulses on the edge that detects the abort condition.
- tx_start is asserted at the earliest ACK_GAP cycles after RESP entry. It is delayed while tx_busy is high and issued on the first cycle tx_busy is sampled low. The FSM leaves RESP on the edge after tx_start.
- At most one response is outstanding; tx_start never pulses while tx_busy is high.

## Test plan
- Good frame, ROW_BYTES=4, ACK_EVERY=2, ROWS=480.
  - Stimulus: A5, 00, 07, 11 22 33 44, checksum 44, DD.
  - Required: tx sequence CC, AA, BC (no AA after the last byte); done pulses once; row_addr=7; row_data=32'h44332211.
- Bad checksum: same frame with checksum 45 -> tx CC, AA, 11; err pulse; row_data/row_addr keep the previous values; done stays 0.
- Address range: addr 01,E0 (480) -> NACK 11 immediately after addr_lo; FSM back in IDLE; addr 01,DF is accepted with CC.
- Timeout, TIMEOUT=100: stop after 2 payload bytes -> err pulse at idle cycle 100, tx 11, FSM in IDLE; the next START_CODE frame completes normally.
- Back-pressure and violation:
  - tx_busy held high for 50 cycles after RESP entry -> tx_start occurs on the first cycle tx_busy is low, not before.
  - A byte injected during RESP -> the response becomes 11 and the FSM returns to IDLE.
- Reset in PAYLOAD -> all outputs 0 on the next edge, no tx_start; junk bytes in IDLE (00, DD) are ignored.
